ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares one ramif RAM port between two requesters (m0, m1) with burst-limited round-robin.
//  Zero-latency grant: the access is issued to the RAM in the same cycle it is granted.
//  Read data is steered back to the issuing requester after a fixed RAM read latency.
//  Sits between engines such as cbcd and a single svram/tbram slave.
// PARAMETERS
//  MAX_BURST  4   max consecutive grants to one requester while the other waits (>=1)
//  RD_LAT     1   cycles from ram.ren to valid ram.rdata (>=1)
//  STAT_W     16  width of statistics counters
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  m0_req     in   1   m0 access request; held with its fields until granted
//  m0_we      in   1   1 = write, 0 = read
//  m0_addr    in   24  m0 word address
//  m0_wdata   in   32  m0 write data
//  m0_gnt     out  1   m0 access accepted this cycle
//  m0_rvalid  out  1   m0 read data valid
//  m0_rdata   out  32  m0 read data
//  m1_*       --   --  identical set for requester m1
//  ram        ramif.mst --  downstream RAM port (addr, wen, wdata, ren out; rdata in)
//  stat_gnt0  out  STAT_W  grants to m0; stat_gnt1 likewise for m1
//  stat_conf  out  STAT_W  cycles where both requested
// BEHAVIOUR
//  State: last (1b, id of last grant), cnt (0..MAX_BURST, consecutive grants to last),
//   rpipe[RD_LAT] of {valid, id}.
//  Reset: last=1, cnt=0, rpipe cleared, stat_* = 0; all outputs 0 while rst=0.
//  sel (comb): only one req -> that one; both req -> last if (cnt!=0 && cnt<MAX_BURST)
//   else ~last; neither -> no grant.
//  Tie after reset or after an idle cycle -> the id != last (m0 first after reset).
//  mN_gnt = mN_req && sel==N (comb); at most one gnt per cycle.
//  ram.addr/wdata = selected requester's fields; ram.wen = gnt & we; ram.ren = gnt & ~we.
//  No grant: ram.wen=ram.ren=0, ram.addr/wdata = 0.
//  Update on grant to g: g==last && cnt!=0 -> cnt=min(cnt+1,MAX_BURST); else last=g, cnt=1.
//  No request in a cycle -> cnt=0, last held.
//  cnt==MAX_BURST with other idle: owner keeps being granted, cnt stays saturated.
//  Read return: rpipe[0] <= {ram.ren, sel id}; shifts one stage per cycle.
//   At the output stage: mN_rvalid = valid && id==N.
//   m0_rdata = m1_rdata = ram.rdata, unmasked.
//  Back-to-back reads from alternating requesters return in issue order, one per cycle.
//  Reset mid-operation: in-flight reads dropped (no rvalid); arbitration restarts at m0.
//  Writes have no response; gnt is the completion.
// CONFIGURATION
//  RAM_ARB_STATS_EN defined:
//   stat_gnt0/stat_gnt1 +1 per grant; stat_conf +1 per cycle with m0_req && m1_req.
//   All three saturate at all-ones.
//  RAM_ARB_STATS_EN undefined: stat_* tied to 0, no counter flops.
// TESTING
//  1 m0 write addr 0x123456 alone -> m0_gnt=1 same cycle, ram.wen=1, ram.addr=0x123456, 1 cycle.
//  2 Both req from reset, MAX_BURST=4, continuous -> grants m0 x4, m1 x4, m0 x4 ...
//  3 MAX_BURST=1, both req continuous -> strict alternation m0,m1,m0...; never two gnt at once.
//  4 RD_LAT=2: m1 read 0x654321, then m0 read next cycle -> m1_rvalid 2 cycles after issue,
//    m0_rvalid the cycle after that, data = ram.rdata in each.
//  5 m1 alone 10 cycles, then m0 joins -> m0 waits until m1 grant count hits MAX_BURST.
//  6 rst low while a read is in flight -> no rvalid afterwards; next tie granted to m0.
//    With RAM_ARB_STATS_EN: counters read 0 after reset.
//    Scenario 2 over 8 cycles -> stat_gnt0=4, stat_gnt1=4, stat_conf=8.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ramif: single-port RAM bus between one master and one slave.
// Ports: addr/wen/wdata/ren driven by master, rdata returned by slave.
interface ramif;
    logic [23:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        ren;
    logic [31:0] rdata;

    modport mst (
        output addr,
        output wen,
        output wdata,
        output ren,
        input  rdata
    );

    modport slv (
        input  addr,
        input  wen,
        input  wdata,
        input  ren,
        output rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters (m0, m1) share one ramif RAM port using
// burst-limited round-robin with zero-latency grant.
// Ports: clk, rst (async, active-low); per requester mN_req/we/addr/wdata in,
//   mN_gnt/rvalid/rdata out; ram (ramif.mst); stat_gnt0/stat_gnt1/stat_conf.
// Build option: define RAM_ARB_STATS_EN to enable the saturating statistics
//   counters; otherwise stat_* are tied to zero and no counter flops exist.
module ram_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [23:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [23:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    ramif.mst                 ram,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conf
);

    localparam int            CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RD_LAT-1:0] rv_q, rv_d;
    logic [RD_LAT-1:0] rid_q, rid_d;

    logic        sel;
    logic        keep;
    logic        any;
    logic        we;
    logic        ren;
    logic        wen;
    logic [23:0] addr;
    logic [31:0] wdata;

    // Owner keeps the port only while its burst is live and unexhausted;
    // cnt==0 (after reset or idle) forces the tie to the other id.
    assign keep = (cnt_q != '0) && (cnt_q < MAXC);
    // Grants are suppressed while reset is held so every output reads 0.
    assign any  = rst && (m0_req || m1_req);

    always_comb begin
        sel = last_q;
        unique case (1'b1)
            (m0_req && !m1_req): sel = 1'b0;
            (m1_req && !m0_req): sel = 1'b1;
            default:             sel = keep ? last_q : ~last_q;
        endcase
    end

    assign m0_gnt = any && !sel;
    assign m1_gnt = any && sel;

    always_comb begin
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (any) begin
            we    = sel ? m1_we    : m0_we;
            addr  = sel ? m1_addr  : m0_addr;
            wdata = sel ? m1_wdata : m0_wdata;
        end
    end

    assign wen       = any && we;
    assign ren       = any && !we;
    assign ram.addr  = addr;
    assign ram.wdata = wdata;
    assign ram.wen   = wen;
    assign ram.ren   = ren;

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (any) begin
            if (sel == last_q && cnt_q != '0) begin
                cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + CW'(1);
            end else begin
                last_d = sel;
                cnt_d  = CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Read-return pipe: one {valid,id} slot per cycle of RAM latency.
    always_comb begin
        rv_d     = rv_q;
        rid_d    = rid_q;
        rv_d[0]  = ren;
        rid_d[0] = sel;
        for (int i = 1; i < RD_LAT; i++) begin
            rv_d[i]  = rv_q[i-1];
            rid_d[i] = rid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
            cnt_q  <= '0;
            rv_q   <= '0;
            rid_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
            rv_q   <= rv_d;
            rid_q  <= rid_d;
        end
    end

    assign m0_rvalid = rv_q[RD_LAT-1] && !rid_q[RD_LAT-1];
    assign m1_rvalid = rv_q[RD_LAT-1] && rid_q[RD_LAT-1];
    assign m0_rdata  = rst ? ram.rdata : '0;
    assign m1_rdata  = rst ? ram.rdata : '0;

`ifdef RAM_ARB_STATS_EN
    logic [STAT_W-1:0] sg0_q, sg0_d;
    logic [STAT_W-1:0] sg1_q, sg1_d;
    logic [STAT_W-1:0] sc_q, sc_d;

    always_comb begin
        sg0_d = sg0_q;
        sg1_d = sg1_q;
        sc_d  = sc_q;
        if (m0_gnt && !(&sg0_q))
            sg0_d = sg0_q + STAT_W'(1);
        if (m1_gnt && !(&sg1_q))
            sg1_d = sg1_q + STAT_W'(1);
        if (m0_req && m1_req && !(&sc_q))
            sc_d = sc_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sg0_q <= '0;
            sg1_q <= '0;
            sc_q  <= '0;
        end else begin
            sg0_q <= sg0_d;
            sg1_q <= sg1_d;
            sc_q  <= sc_d;
        end
    end

    assign stat_gnt0 = sg0_q;
    assign stat_gnt1 = sg1_q;
    assign stat_conf = sc_q;
`else
    assign stat_gnt0 = '0;
    assign stat_gnt1 = '0;
    assign stat_conf = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed steps with a read-return scoreboard.
// Instance A: MAX_BURST=4, RD_LAT=2; instance B: MAX_BURST=1, RD_LAT=1.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [23:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic        a_g0, a_g1, a_v0, a_v1;
    logic [31:0] a_d0, a_d1;
    logic [15:0] a_s0, a_s1, a_sc;
    logic        b_g0, b_g1, b_v0, b_v1;
    logic [31:0] b_d0, b_d1;
    logic [15:0] b_s0, b_s1, b_sc;

    ramif ramA ();
    ramif ramB ();

    int checks = 0;
    int errors = 0;
    int exp_sg = 0;
    int exp_sc = 0;
    logic [32:0] sbq [$];
    logic [31:0] rA1;

    ram_arbiter #(.MAX_BURST(4), .RD_LAT(2), .STAT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(a_g0), .m0_rvalid(a_v0),
        .m0_rdata(a_d0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(a_g1), .m1_rvalid(a_v1),
        .m1_rdata(a_d1),
        .ram(ramA),
        .stat_gnt0(a_s0), .stat_gnt1(a_s1), .stat_conf(a_sc)
    );

    ram_arbiter #(.MAX_BURST(1), .RD_LAT(1), .STAT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(b_g0), .m0_rvalid(b_v0),
        .m0_rdata(b_d0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(b_g1), .m1_rvalid(b_v1),
        .m1_rdata(b_d1),
        .ram(ramB),
        .stat_gnt0(b_s0), .stat_gnt1(b_s1), .stat_conf(b_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model for A: two-cycle read, data = {A5, addr}.
    always @(posedge clk) begin
        rA1        <= ramA.ren ? {8'hA5, ramA.addr} : 32'h0;
        ramA.rdata <= rA1;
    end
    assign ramB.rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [23:0] ad0,
                       input logic r1, input logic w1, input logic [23:0] ad1);
        m0_req   = r0;
        m0_we    = w0;
        m0_addr  = ad0;
        m0_wdata = {8'h5A, ad0};
        m1_req   = r1;
        m1_we    = w1;
        m1_addr  = ad1;
        m1_wdata = {8'h3C, ad1};
    endtask

    task automatic mon();
        logic [32:0] e;
        chk("A_onehot", 64'(a_g0 & a_g1), 64'd0);
        chk("B_onehot", 64'(b_g0 & b_g1), 64'd0);
        if (a_v0 || a_v1) begin
            if (sbq.size() == 0) begin
                chk("A_rv_unexp", 64'(a_v0 | a_v1), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("A_rv_id", 64'({a_v1, a_v0}), e[32] ? 64'd2 : 64'd1);
                chk("A_rv_data", 64'(e[32] ? a_d1 : a_d0), 64'(e[31:0]));
            end
        end
        if (a_g0 && !m0_we)
            sbq.push_back({1'b0, 8'hA5, m0_addr});
        if (a_g1 && !m1_we)
            sbq.push_back({1'b1, 8'hA5, m1_addr});
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_g0"}, 64'(a_g0), 64'd0);
        chk({tag, "_g1"}, 64'(a_g1), 64'd0);
        chk({tag, "_rv"}, 64'({a_v0, a_v1}), 64'd0);
        chk({tag, "_ren"}, 64'({ramA.ren, ramA.wen}), 64'd0);
        chk({tag, "_addr"}, 64'(ramA.addr), 64'd0);
        chk({tag, "_stat"}, {16'h0, a_s0, a_s1, a_sc}, 64'd0);
        chk({tag, "_bg"}, 64'({b_g0, b_g1}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sbq.delete();
        mid();
        chk_zero("rst");
        nxt();
        rst = 1'b1;
    endtask

    initial begin
`ifdef RAM_ARB_STATS_EN
        exp_sg = 4;
        exp_sc = 8;
`endif
        rst = 1'b0;
        drv(1'b1, 1'b0, 24'h000111, 1'b1, 1'b0, 24'h000222);
        @(posedge clk);
        #1;
        mid();
        chk_zero("por");
        nxt();
        rst = 1'b1;

        // Lone write from m0
        drv(1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 24'h0);
        mid();
        chk("t1_g0", 64'(a_g0), 64'd1);
        chk("t1_g1", 64'(a_g1), 64'd0);
        chk("t1_wen", 64'({ramA.wen, ramA.ren}), 64'd2);
        chk("t1_addr", 64'(ramA.addr), 64'h123456);
        chk("t1_wdata", 64'(ramA.wdata), 64'h5A123456);
        nxt();
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        mid();
        chk("t1_idle_g", 64'({a_g0, a_g1}), 64'd0);
        chk("t1_idle_wen", 64'({ramA.wen, ramA.ren}), 64'd0);
        chk("t1_idle_addr", 64'(ramA.addr), 64'd0);
        nxt();

        // Both requesting continuously from reset
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drv(1'b1, 1'b1, 24'(16 + i), 1'b1, 1'b1, 24'(32 + i));
            mid();
            chk("t2_a_g0", 64'(a_g0), 64'(((i / 4) % 2) == 0));
            chk("t2_a_g1", 64'(a_g1), 64'(((i / 4) % 2) == 1));
            chk("t2_b_g0", 64'(b_g0), 64'((i % 2) == 0));
            chk("t2_b_g1", 64'(b_g1), 64'((i % 2) == 1));
            if (i == 8) begin
                chk("t2_a_sg0", 64'(a_s0), 64'(exp_sg));
                chk("t2_a_sg1", 64'(a_s1), 64'(exp_sg));
                chk("t2_a_sc", 64'(a_sc), 64'(exp_sc));
                chk("t2_b_sg0", 64'(b_s0), 64'(exp_sg));
                chk("t2_b_sc", 64'(b_sc), 64'(exp_sc));
            end
            nxt();
        end
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        mid();
        nxt();

        // Alternating reads, m1 then m0
        drv(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h654321);
        mid();
        chk("t4_g1", 64'(a_g1), 64'd1);
        chk("t4_ren", 64'({ramA.ren, ramA.wen}), 64'd2);
        chk("t4_addr", 64'(ramA.addr), 64'h654321);
        nxt();
        drv(1'b1, 1'b0, 24'h000ABC, 1'b0, 1'b0, 24'h0);
        mid();
        chk("t4_g0", 64'(a_g0), 64'd1);
        chk("t4_rv_early", 64'({a_v0, a_v1}), 64'd0);
        chk("t4_b_rv1", 64'({b_v1, b_v0}), 64'd2);
        chk("t4_b_rd1", 64'(b_d1), 64'd0);
        nxt();
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        mid();
        chk("t4_rv1", 64'({a_v1, a_v0}), 64'd2);
        chk("t4_rd1", 64'(a_d1), 64'hA5654321);
        nxt();
        mid();
        chk("t4_rv0", 64'({a_v1, a_v0}), 64'd1);
        chk("t4_rd0", 64'(a_d0), 64'hA5000ABC);
        nxt();
        mid();
        chk("t4_rv_done", 64'({a_v1, a_v0}), 64'd0);
        nxt();

        // m1 alone 10 cycles, then m0 joins
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 1'b1, 24'h0, 1'b1, 1'b1, 24'(64 + i));
            mid();
            chk("t5_solo_g1", 64'({a_g1, a_g0}), 64'd2);
            nxt();
        end
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b1, 24'(80 + i), 1'b1, 1'b1, 24'(96 + i));
            mid();
            chk("t5_join_g0", 64'(a_g0), 64'(i < 4));
            chk("t5_join_g1", 64'(a_g1), 64'(i >= 4));
            nxt();
        end
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        mid();
        nxt();
        for (int i = 0; i < 5; i++) begin
            drv(i >= 2, 1'b1, 24'(112 + i), 1'b1, 1'b1, 24'(128 + i));
            mid();
            chk("t5_wait_g0", 64'(a_g0), 64'(i == 4));
            chk("t5_wait_g1", 64'(a_g1), 64'(i < 4));
            nxt();
        end

        // Reset while a read is in flight
        drv(1'b1, 1'b0, 24'h00F00D, 1'b0, 1'b0, 24'h0);
        mid();
        chk("t6_g0", 64'(a_g0), 64'd1);
        nxt();
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t6_no_rv", 64'({a_v0, a_v1}), 64'd0);
            nxt();
        end
        drv(1'b1, 1'b1, 24'h000100, 1'b1, 1'b1, 24'h000200);
        mid();
        chk("t6_tie_g0", 64'({a_g1, a_g0}), 64'd1);
        nxt();
        mid();
        chk("t6_keep_g0", 64'({a_g1, a_g0}), 64'd1);
        nxt();
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        mid();
        nxt();
        drv(1'b1, 1'b1, 24'h000101, 1'b1, 1'b1, 24'h000201);
        mid();
        chk("t6_idle_tie_g1", 64'({a_g1, a_g0}), 64'd2);
        nxt();
        drv(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            nxt();
        end

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
